// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and constants for the MEM pipeline stage
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    localparam int          DMEM_AW_DEF  = 10;
    localparam int          TIMEOUT_DEF  = 64;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // One write-back register entry handed to the WB stage
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd_add;
        logic        err;
    } wb_rec_t;

    // A word address is usable only if every bit above the memory width is zero
    function automatic logic addr_in_range(input logic [31:0] a, input int aw);
        logic [31:0] upper;
        upper = (aw >= 32) ? 32'd0 : (a >> aw);
        return (upper == 32'd0);
    endfunction

endpackage

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory access FSM, timeout and WB register
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int          DMEM_AW  = DMEM_AW_DEF,
    parameter int          TIMEOUT  = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_2_mem,
    input  logic [31:0]        rd_2_mem,
    input  logic [31:0]        A_2_mem,
    input  logic               mem_read_2_mem,
    input  logic               mem_write_2_mem,
    input  logic               mem_to_reg_2_mem,
    input  logic [4:0]         rd_add_value_2_mem,
    output logic               stall_2_ex,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_gnt,
    input  logic               dmem_rvalid,
    input  logic [31:0]        dmem_rdata,
    output logic               wb_valid_2_wb,
    output logic [31:0]        wb_data_2_wb,
    output logic [4:0]         rd_add_value_2_wb,
    output logic               mem_err_2_wb
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_e state, state_next;

    // Operation latched at capture; the EX register may change while we stall
    logic [DMEM_AW-1:0] addr_q;
    logic [31:0]        data_q;
    logic               we_q;
    logic               m2r_q;
    logic [4:0]         rd_q;

    logic [CW-1:0]      tcnt;
    wb_rec_t            wb_q, wb_d;

    logic is_mem, in_range, capture, timeout_hit;
    logic [31:0] load_data;

    // Decode of the incoming EX entry and the timeout condition
    always_comb begin
        is_mem      = valid_2_mem & (mem_read_2_mem | mem_write_2_mem);
        in_range    = addr_in_range(A_2_mem, DMEM_AW);
        capture     = (state == IDLE) & is_mem & in_range;
        timeout_hit = (tcnt == CW'(TIMEOUT - 1));
        load_data   = m2r_q ? dmem_rdata : data_q;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; a handshake beats a timeout landing on the same cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (we_q || dmem_rvalid) begin
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (dmem_rvalid || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: memory port driven only while requesting, EX held outside IDLE
    always_comb begin
        stall_2_ex = (state != IDLE);
        dmem_req   = (state == REQ);
        dmem_we    = dmem_req & we_q;
        dmem_addr  = dmem_req ? addr_q : '0;
        dmem_wdata = dmem_we ? data_q : 32'd0;
    end

    // Timeout counter: restarts on every state change, counts while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state_next != state) begin
            tcnt <= '0;
        end else if (state != IDLE) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Capture registers for the memory operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= 32'd0;
            we_q   <= 1'b0;
            m2r_q  <= 1'b0;
            rd_q   <= 5'd0;
        end else if (capture) begin
            addr_q <= A_2_mem[DMEM_AW-1:0];
            data_q <= rd_2_mem;
            we_q   <= mem_write_2_mem;
            m2r_q  <= mem_to_reg_2_mem;
            rd_q   <= rd_add_value_2_mem;
        end
    end

    // Next WB entry; valid and err fall back to 0 whenever nothing completes
    always_comb begin
        wb_d       = wb_q;
        wb_d.valid = 1'b0;
        wb_d.err   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_2_mem && !is_mem) begin
                    wb_d.valid  = 1'b1;
                    wb_d.data   = rd_2_mem;
                    wb_d.rd_add = rd_add_value_2_mem;
                end else if (is_mem && !in_range) begin
                    wb_d.valid  = mem_read_2_mem & ~mem_write_2_mem;
                    wb_d.data   = ERR_DATA;
                    wb_d.rd_add = rd_add_value_2_mem;
                    wb_d.err    = 1'b1;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (!we_q && dmem_rvalid) begin
                        wb_d.valid  = 1'b1;
                        wb_d.data   = load_data;
                        wb_d.rd_add = rd_q;
                    end
                end else if (timeout_hit) begin
                    wb_d.valid  = ~we_q;
                    wb_d.data   = ERR_DATA;
                    wb_d.rd_add = rd_q;
                    wb_d.err    = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    wb_d.valid  = 1'b1;
                    wb_d.data   = load_data;
                    wb_d.rd_add = rd_q;
                end else if (timeout_hit) begin
                    wb_d.valid  = 1'b1;
                    wb_d.data   = ERR_DATA;
                    wb_d.rd_add = rd_q;
                    wb_d.err    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // WB pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_valid_2_wb     = wb_q.valid;
    assign wb_data_2_wb      = wb_q.data;
    assign rd_add_value_2_wb = wb_q.rd_add;
    assign mem_err_2_wb      = wb_q.err;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int          AW   = 10;
    localparam int          TO   = 64;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_2_mem;
    logic [31:0]   rd_2_mem;
    logic [31:0]   A_2_mem;
    logic          mem_read_2_mem;
    logic          mem_write_2_mem;
    logic          mem_to_reg_2_mem;
    logic [4:0]    rd_add_value_2_mem;
    logic          stall_2_ex;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_rvalid;
    logic [31:0]   dmem_rdata;
    logic          wb_valid_2_wb;
    logic [31:0]   wb_data_2_wb;
    logic [4:0]    rd_add_value_2_wb;
    logic          mem_err_2_wb;

    always #5 clk = ~clk;

    mem_access_stage #(.DMEM_AW(AW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .reset(reset),
        .valid_2_mem(valid_2_mem), .rd_2_mem(rd_2_mem), .A_2_mem(A_2_mem),
        .mem_read_2_mem(mem_read_2_mem), .mem_write_2_mem(mem_write_2_mem),
        .mem_to_reg_2_mem(mem_to_reg_2_mem), .rd_add_value_2_mem(rd_add_value_2_mem),
        .stall_2_ex(stall_2_ex), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid_2_wb(wb_valid_2_wb), .wb_data_2_wb(wb_data_2_wb),
        .rd_add_value_2_wb(rd_add_value_2_wb), .mem_err_2_wb(mem_err_2_wb)
    );

    int ncomp = 0;
    int nfail = 0;
    logic [31:0] mem_model [int unsigned];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One EX entry presented to the stage; the bench also plays the memory.
    // g: request cycles before gnt (>=TO means never); r: cycles from gnt to rvalid (0 = same cycle, >TO never)
    task automatic run_op(input string tag, input logic [31:0] rdv, input logic [31:0] a,
                          input logic rf, input logic wf, input logic m2r, input logic [4:0] rda,
                          input int g, input int r);
        logic is_mem, st, inr, ld;
        int exp_stall, exp_req, k, reqs;
        logic exp_v, exp_e;
        logic [31:0] exp_d, ld_val;
        is_mem = rf | wf;
        st     = wf;
        ld     = is_mem & ~st;
        inr    = (a < 32'(1 << AW));
        ld_val = m2r ? mem_rd(a) : rdv;
        exp_d  = 32'd0;
        if (!is_mem) begin
            exp_stall = 0; exp_req = 0; exp_v = 1'b1; exp_d = rdv; exp_e = 1'b0;
        end else if (!inr) begin
            exp_stall = 0; exp_req = 0; exp_v = ld; exp_d = ERRD; exp_e = 1'b1;
        end else if (st) begin
            exp_v = 1'b0;
            if (g < TO) begin exp_stall = g + 1; exp_req = g + 1; exp_e = 1'b0; end
            else begin exp_stall = TO; exp_req = TO; exp_e = 1'b1; end
        end else begin
            exp_v = 1'b1;
            if (g >= TO) begin exp_stall = TO; exp_req = TO; exp_d = ERRD; exp_e = 1'b1; end
            else if (r == 0) begin exp_stall = g + 1; exp_req = g + 1; exp_d = ld_val; exp_e = 1'b0; end
            else if (r <= TO) begin exp_stall = g + 1 + r; exp_req = g + 1; exp_d = ld_val; exp_e = 1'b0; end
            else begin exp_stall = g + 1 + TO; exp_req = g + 1; exp_d = ERRD; exp_e = 1'b1; end
        end

        valid_2_mem = 1'b1; rd_2_mem = rdv; A_2_mem = a;
        mem_read_2_mem = rf; mem_write_2_mem = wf; mem_to_reg_2_mem = m2r;
        rd_add_value_2_mem = rda; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        if (exp_stall == 0) chk({tag, "_noreq"}, {31'd0, dmem_req}, 32'd0);
        k = 0; reqs = 0;
        while (stall_2_ex === 1'b1 && k < 2 * TO + 8) begin
            reqs += int'(dmem_req);
            // garbage on the EX register must be ignored while stalled
            valid_2_mem = 1'b1; rd_2_mem = $urandom; A_2_mem = $urandom;
            mem_read_2_mem = 1'($urandom); mem_write_2_mem = 1'($urandom);
            mem_to_reg_2_mem = 1'($urandom); rd_add_value_2_mem = 5'($urandom);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            if (dmem_req && k < g) dmem_rvalid = 1'($urandom);
            if (dmem_req && k == g) begin
                dmem_gnt = 1'b1;
                chk({tag, "_addr"}, {22'd0, dmem_addr}, a);
                chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, st});
                if (st) begin
                    chk({tag, "_wdata"}, dmem_wdata, rdv);
                    mem_model[a] = rdv;
                end else if (r == 0) begin
                    dmem_rvalid = 1'b1; dmem_rdata = mem_rd(a);
                end
            end
            if (ld && !dmem_req && g < TO && r > 0 && k == g + r) begin
                dmem_rvalid = 1'b1; dmem_rdata = mem_rd(a);
            end
            @(posedge clk); #1;
            k++;
        end
        valid_2_mem = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk({tag, "_stall_cycles"}, k, exp_stall);
        chk({tag, "_req_cycles"}, reqs, exp_req);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid_2_wb}, {31'd0, exp_v});
        chk({tag, "_mem_err"}, {31'd0, mem_err_2_wb}, {31'd0, exp_e});
        if (exp_v) begin
            chk({tag, "_wb_data"}, wb_data_2_wb, exp_d);
            chk({tag, "_rd_add"}, {27'd0, rd_add_value_2_wb}, {27'd0, rda});
        end
        // idle cycle with a stale response on the bus
        dmem_rvalid = 1'b1; dmem_rdata = $urandom;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk({tag, "_idle_valid"}, {31'd0, wb_valid_2_wb}, 32'd0);
        chk({tag, "_idle_err"}, {31'd0, mem_err_2_wb}, 32'd0);
        chk({tag, "_idle_stall"}, {31'd0, stall_2_ex}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rdv;
        int kind, g, r;
        reset = 1'b1; valid_2_mem = 1'b0; rd_2_mem = 32'd0; A_2_mem = 32'd0;
        mem_read_2_mem = 1'b0; mem_write_2_mem = 1'b0; mem_to_reg_2_mem = 1'b0;
        rd_add_value_2_mem = 5'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        #2;
        chk("rst_stall", {31'd0, stall_2_ex}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid_2_wb}, 32'd0);
        chk("rst_wb_data", wb_data_2_wb, 32'd0);
        chk("rst_err", {31'd0, mem_err_2_wb}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        mem_model[32'h10] = 32'hCAFE_0001;
        run_op("alu", 32'h11, 32'h0, 1'b0, 1'b0, 1'b0, 5'd5, 0, 0);
        run_op("ldw_wait", 32'h0, 32'h10, 1'b1, 1'b0, 1'b1, 5'd7, 2, 1);
        run_op("stw_3ff", 32'h55, 32'h3FF, 1'b0, 1'b1, 1'b0, 5'd0, 0, 0);
        run_op("ldw_3ff_same", 32'h0, 32'h3FF, 1'b1, 1'b0, 1'b1, 5'd9, 0, 0);
        run_op("ldw_oor", 32'h0, 32'h400, 1'b1, 1'b0, 1'b1, 5'd3, 0, 0);
        run_op("stw_oor", 32'h77, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd3, 0, 0);
        run_op("ldw_timeout", 32'h0, 32'h20, 1'b1, 1'b0, 1'b1, 5'd11, 0, TO + 1);
        run_op("ldw_rv_at_limit", 32'h0, 32'h10, 1'b1, 1'b0, 1'b1, 5'd12, TO - 1, TO);
        run_op("stw_gnt_timeout", 32'h99, 32'h21, 1'b0, 1'b1, 1'b0, 5'd0, TO, 0);
        run_op("rw_as_store", 32'hA5A5_0000, 32'h22, 1'b1, 1'b1, 1'b1, 5'd4, 1, 0);
        run_op("ldw_m2r0", 32'h1234_ABCD, 32'h22, 1'b1, 1'b0, 1'b0, 5'd13, 1, 2);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            ra   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
            rdv  = $urandom;
            g    = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, 3);
            r    = ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(0, 3);
            case (kind)
                0: run_op("rnd_alu", rdv, ra, 1'b0, 1'b0, 1'($urandom), 5'($urandom), g, r);
                1: run_op("rnd_st", rdv, ra, 1'b0, 1'b1, 1'($urandom), 5'($urandom), g, r);
                default: run_op("rnd_ld", rdv, ra, 1'b1, 1'b0, 1'($urandom), 5'($urandom), g, r);
            endcase
        end

        // reset while waiting for read data, then a late response
        valid_2_mem = 1'b1; A_2_mem = 32'h30; rd_2_mem = 32'h0;
        mem_read_2_mem = 1'b1; mem_write_2_mem = 1'b0; mem_to_reg_2_mem = 1'b1;
        rd_add_value_2_mem = 5'd21;
        @(posedge clk); #1;
        valid_2_mem = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("rstmid_in_wait", {31'd0, stall_2_ex}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("rstmid_stall", {31'd0, stall_2_ex}, 32'd0);
        chk("rstmid_req", {31'd0, dmem_req}, 32'd0);
        chk("rstmid_wb_valid", {31'd0, wb_valid_2_wb}, 32'd0);
        chk("rstmid_rd_add", {27'd0, rd_add_value_2_wb}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("late_rv_valid", {31'd0, wb_valid_2_wb}, 32'd0);
        chk("late_rv_data", wb_data_2_wb, 32'd0);
        chk("late_rv_stall", {31'd0, stall_2_ex}, 32'd0);

        run_op("post_rst_alu", 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0, 1'b0, 5'd31, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
